pipe_sink_fifo: RTL

Downstream consumer stage for the two-write-port pipe register chain. It captures each valid word presented by the last pipe register, buffers up to DEPTH words, and re-issues them to a consumer over a valid/ready handshake. It drives the chain's `low_empty` input: high means "this stage accepts a word at the next edge". The last pipe register releases its word exactly when it sees `low_empty` high, so a word presented while `low_empty` is high is never dropped.

---
 rtl/pipe_sink_fifo.sv | 74 +++++++
 1 files changed

// File: rtl/pipe_sink_fifo.sv
// Sink stage for the pipe register chain: buffers up to DEPTH words and re-issues them over valid/ready.
// Optional occupancy outputs (level, afull) are enabled with `define PIPE_SINK_LEVEL_EN.
module pipe_sink_fifo #(
   parameter int DSIZE = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [DSIZE-1:0] in_data,
   output logic             low_empty,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_SINK_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] level,
   output logic                   afull
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [DSIZE-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic             push;
   logic             pop;

   // Handshake flags come only from cnt, so upstream never sees a path from out_ready.
   assign low_empty = (cnt != CNT_FULL);
   assign out_valid = (cnt != '0);
   assign out_data  = out_valid ? mem[rp] : '0;
   assign push      = in_valid && low_empty;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wp] <= in_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            wp <= wp + PTR_ONE;
         end
         if (pop) begin
            rp <= rp + PTR_ONE;
         end
         if (push && !pop) begin
            cnt <= cnt + CNT_ONE;
         end else if (pop && !push) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

`ifdef PIPE_SINK_LEVEL_EN
   localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 1);

   assign level = cnt;
   assign afull = (cnt >= CNT_AFULL);
`endif

endmodule
